// File: rtl/tlm_mchan_fifo.sv
`default_nettype none
// =============================================================================
// Module  : tlm_mchan_fifo
// Brief   : NUM_CH put channels, per-channel circular buffers, arbitrated into
//           one registered get port tagged with the source channel.
// Revision: 1.0 - initial release
// =============================================================================
module tlm_mchan_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_CH-1:0]         put_valid_i,
  output logic [NUM_CH-1:0]         put_ready_o,
  input  logic [NUM_CH*DATA_W-1:0]  put_data_i,
  input  logic [NUM_CH-1:0]         flush_i,
  output logic                      get_valid_o,
  input  logic                      get_ready_i,
  output logic [DATA_W-1:0]         get_data_o,
  output logic [CH_W-1:0]           get_ch_o,
  output logic [NUM_CH*CNT_W-1:0]   used_o,
  output logic [NUM_CH-1:0]         full_o,
  output logic [NUM_CH-1:0]         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];

  logic [CH_W-1:0]   last_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;

  logic [CH_W-1:0]   grant_d;
  logic              grant_vld_d;
  logic              free_w;
  logic [NUM_CH-1:0] full_w, empty_w, push_w, pop_w, elig_w;

  assign free_w = ~out_valid_q | get_ready_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign full_w[c]  = (cnt_q[c] == CNT_W'(DEPTH));
    assign empty_w[c] = (cnt_q[c] == '0);
    // A channel being flushed may neither accept nor be granted this cycle.
    assign push_w[c]  = put_valid_i[c] & ~full_w[c] & ~flush_i[c];
    assign elig_w[c]  = ~empty_w[c] & ~flush_i[c];
    assign pop_w[c]   = free_w & grant_vld_d & (grant_d == CH_W'(c));
    assign put_ready_o[c]           = ~full_w[c] & ~flush_i[c];
    assign used_o[c*CNT_W +: CNT_W] = cnt_q[c];
  end

  assign full_o      = full_w;
  assign empty_o     = empty_w;
  assign get_valid_o = out_valid_q;
  assign get_data_o  = out_data_q;
  assign get_ch_o    = out_ch_q;

  always_comb begin
    int idx;
    idx         = 0;
    grant_d     = '0;
    grant_vld_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 1) idx = i;
      else               idx = (int'(last_q) + 1 + i) % NUM_CH;
      if (!grant_vld_d && elig_w[idx[CH_W-1:0]]) begin
        grant_vld_d = 1'b1;
        grant_d     = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_w[c]) mem_q[c][wr_ptr_q[c]] <= put_data_i[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      // Pretend the last grant was the top channel so channel 0 is searched first.
      last_q      <= CH_W'(NUM_CH - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      if (free_w) begin
        out_valid_q <= grant_vld_d;
        if (grant_vld_d) begin
          out_data_q <= mem_q[grant_d][rd_ptr_q[grant_d]];
          out_ch_q   <= grant_d;
          last_q     <= grant_d;
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush_i[c]) begin
          wr_ptr_q[c] <= '0;
          rd_ptr_q[c] <= '0;
          cnt_q[c]    <= '0;
        end else begin
          if (push_w[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
          if (pop_w[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
          case ({push_w[c], pop_w[c]})
            2'b10:   cnt_q[c] <= cnt_q[c] + 1'b1;
            2'b01:   cnt_q[c] <= cnt_q[c] - 1'b1;
            default: cnt_q[c] <= cnt_q[c];
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
